// File: rtl/instruction_memory.sv
// Instruction store. The byte-addressed PC selects a word; the fetch is registered one cycle later.
// A synchronous load port writes the program image at boot.
module instruction_memory #(
  parameter int unsigned N         = 32,
  parameter int unsigned DEPTH     = 4096,
  parameter string       INIT_FILE = ""
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [13:0]  address,
  output logic [N-1:0] instruction,
  output logic         misaligned,
  input  logic         prog_en,
  input  logic [13:0]  prog_addr,
  input  logic [N-1:0] prog_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N-1:0] mem [DEPTH];

  logic [11:0]  rd_word;
  logic [11:0]  wr_word;
  logic         rd_in_range;
  logic         wr_in_range;
  logic         wr_en;
  logic [N-1:0] instr_d, instr_q;
  logic         misal_d, misal_q;

  // Byte offsets within a load word carry no meaning.
  logic unused_prog_lsb;
  assign unused_prog_lsb = ^prog_addr[1:0];

  assign rd_word     = address[13:2];
  assign wr_word     = prog_addr[13:2];
  assign rd_in_range = ({20'd0, rd_word} < DEPTH);
  assign wr_in_range = ({20'd0, wr_word} < DEPTH);
  // Loads are ignored while reset is held.
  assign wr_en       = prog_en & rst & wr_in_range;

  // Zero every word so no X can escape.
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i] = '0;
    end
  end

  // Next fetch value: out-of-range words read as zero.
  always_comb begin
    instr_d = '0;
    if (rd_in_range) begin
      instr_d = mem[rd_word[AW-1:0]];
    end
    misal_d = (address[1:0] != 2'b00);
  end

  // Program-load write port; the read above sees the old word on a same-edge hit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_word[AW-1:0]] <= prog_data;
    end
  end

  // Registered fetch outputs, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q <= '0;
      misal_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      misal_q <= misal_d;
    end
  end

  assign instruction = instr_q;
  assign misaligned  = misal_q;

endmodule

// File: tb/tb_instruction_memory.sv
// Bench for instruction_memory: directed literal checks plus a randomized run against a word-array model.
module tb_instruction_memory;

  localparam int unsigned N     = 32;
  localparam int unsigned DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [13:0]  address;
  logic [N-1:0] instruction;
  logic         misaligned;
  logic         prog_en;
  logic [13:0]  prog_addr;
  logic [N-1:0] prog_data;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  // Reference model: a plain array of words plus the expected registered outputs.
  logic [N-1:0] model_mem [DEPTH];
  logic [N-1:0] exp_instr;
  logic         exp_mis;

  instruction_memory #(
    .N        (N),
    .DEPTH    (DEPTH),
    .INIT_FILE("")
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .address    (address),
    .instruction(instruction),
    .misaligned (misaligned),
    .prog_en    (prog_en),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
    exp_instr = '0;
    exp_mis   = 1'b0;
  end

  // Model: fetch sees the memory before this edge's write; reset clears outputs at once.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_instr = '0;
      exp_mis   = 1'b0;
    end else begin
      int ri, wi;
      ri = int'(address) / 4;
      wi = int'(prog_addr) / 4;
      exp_instr = (ri < int'(DEPTH)) ? model_mem[ri] : '0;
      exp_mis   = (int'(address) % 4) != 0;
      if (prog_en && wi < int'(DEPTH)) model_mem[wi] = prog_data;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      total++;
      if (instruction !== exp_instr || misaligned !== exp_mis) begin
        bad++;
        $display("FAIL model t=%0t addr=%0d got instr=%h mis=%b want instr=%h mis=%b",
                 $time, address, instruction, misaligned, exp_instr, exp_mis);
      end
    end
  end

  task automatic chk(input string name, input logic [N-1:0] act_i, input logic act_m,
                     input logic [N-1:0] want_i, input logic want_m);
    total++;
    if (act_i !== want_i || act_m !== want_m) begin
      bad++;
      $display("FAIL %s got instr=%h mis=%b want instr=%h mis=%b",
               name, act_i, act_m, want_i, want_m);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, return just after the rising edge.
  task automatic cyc(input logic [13:0] a, input logic pe, input logic [13:0] pa,
                     input logic [N-1:0] pd);
    @(negedge clk);
    #1;
    address   = a;
    prog_en   = pe;
    prog_addr = pa;
    prog_data = pd;
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] words [5];

  initial begin
    words[0] = 32'h00000013;
    words[1] = 32'h11111111;
    words[2] = 32'h22222222;
    words[3] = 32'h33333333;
    words[4] = 32'h44444444;

    rst = 1'b1; address = '0; prog_en = 1'b0; prog_addr = '0; prog_data = '0;
    #1 rst = 1'b0;
    #1;
    chk("reset_hold", instruction, misaligned, 32'h0, 1'b0);
    check_en = 1'b1;

    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("first_fetch_word0", instruction, misaligned, 32'h0, 1'b0);

    for (int i = 0; i < 5; i++) cyc(14'd0, 1'b1, 14'(4 * i), words[i]);
    cyc(14'd0, 1'b0, 14'd0, '0);
    chk("fetch_0", instruction, misaligned, 32'h00000013, 1'b0);
    for (int i = 1; i < 5; i++) begin
      cyc(14'(4 * i), 1'b0, 14'd0, '0);
      chk($sformatf("fetch_%0d", 4 * i), instruction, misaligned, words[i], 1'b0);
    end

    cyc(14'd5, 1'b0, 14'd0, '0);
    chk("misaligned_5", instruction, misaligned, 32'h11111111, 1'b1);
    cyc(14'd8, 1'b0, 14'd0, '0);
    chk("aligned_8", instruction, misaligned, 32'h22222222, 1'b0);

    cyc(14'd8, 1'b1, 14'd8, 32'hDEADBEEF);
    chk("rbw_old", instruction, misaligned, 32'h22222222, 1'b0);
    cyc(14'd8, 1'b0, 14'd0, '0);
    chk("rbw_new", instruction, misaligned, 32'hDEADBEEF, 1'b0);

    cyc(14'd64, 1'b0, 14'd0, '0);
    chk("oor_read", instruction, misaligned, 32'h0, 1'b0);
    cyc(14'd67, 1'b1, 14'd64, 32'hCAFEF00D);
    chk("oor_read_mis", instruction, misaligned, 32'h0, 1'b1);
    cyc(14'd0, 1'b0, 14'd0, '0);
    chk("oor_write_word0", instruction, misaligned, 32'h00000013, 1'b0);
    cyc(14'd4, 1'b0, 14'd0, '0);
    chk("oor_write_word1", instruction, misaligned, 32'h11111111, 1'b0);

    cyc(14'd12, 1'b0, 14'd0, '0);
    chk("pre_reset_word3", instruction, misaligned, 32'h33333333, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_drop", instruction, misaligned, 32'h0, 1'b0);
    prog_en = 1'b1; prog_addr = 14'd12; prog_data = 32'hBADBAD00;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_held", instruction, misaligned, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1; prog_en = 1'b0; address = 14'd12;
    @(posedge clk);
    #1;
    chk("post_reset_word3", instruction, misaligned, 32'h33333333, 1'b0);
    cyc(14'd1, 1'b0, 14'd0, '0);
    chk("post_reset_word0", instruction, misaligned, 32'h00000013, 1'b1);

    // Randomized traffic: some out-of-range addresses, occasional async reset pulses.
    for (int i = 0; i < 500; i++) begin
      cyc(14'($urandom_range(0, 95)), 1'($urandom_range(0, 9) < 3),
          14'($urandom_range(0, 95)), $urandom);
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1'b0;
        #1;
        chk("rand_async_reset", instruction, misaligned, 32'h0, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
      end
    end

    // Final sweep reads back every word against the model.
    for (int w = 0; w < int'(DEPTH); w++) cyc(14'(4 * w), 1'b0, 14'd0, '0);
    @(negedge clk);
    check_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
